trng_multi_ch_csr: RTL
======================

// Module: trng_multi_ch_csr
// PURPOSE
//  Next-generation TRNG register map: CSR bank for N_CH entropy channels (LFSR + ring oscillator + TMW counter, external).
//  Round-robin collects channel output words into a FIFO, readable through a pop-on-read DATA register.
//  Sits between the bus slave port and the channel array; replaces the single-channel map.
// PARAMETERS
//  ADDR_WIDTH  13  byte address width; registers decoded on addr_i[ADDR_WIDTH-1:4]
//  N_CH        4   number of entropy channels, 1..8
//  LFSR_WIDTH  32  channel word / polynomial / seed width, <=32
//  TMW_WIDTH   23  time-measurement-window counter width, <=32
//  FIFO_DEPTH  16  sample FIFO depth, power of 2, >=2
// PORTS
//  clk            in   1                 single clock
//  rst            in   1                 asynchronous active-low reset
//  en_i           in   1                 bus access strobe
//  we_i           in   4                 byte write enables; any set = write
//  addr_i         in   ADDR_WIDTH        byte address
//  wrdata_i       in   32                write data
//  rdata_o        out  32                read data, registered
//  ch_en_o        out  N_CH              per-channel run enable
//  ch_poly_o      out  LFSR_WIDTH        shared LFSR polynomial
//  ch_tmw_max_o   out  TMW_WIDTH         shared TMW max count
//  ch_seed_o      out  LFSR_WIDTH        seed value
//  ch_seed_we_o   out  N_CH              one-cycle seed load pulse per channel
//  ch_data_i      in   N_CH*LFSR_WIDTH   channel words, channel k at [k*LFSR_WIDTH +: LFSR_WIDTH]
//  ch_valid_i     in   N_CH              channel word valid, one-cycle pulse per word
//  irq_o          out  1                 level interrupt (IRQ_EN only, else tied 0)
// BEHAVIOUR
//  Reset: all registers, FIFO pointers, FSM=IDLE; rdata_o=0, ch_*_o=0, irq_o=0.
//  Register map (index = addr_i[ADDR_WIDTH-1:4]); writes honour we_i byte lanes; unmapped: read 0, write ignored:
//   1 CTRL     RW  [0] start, [1] flush (self-clearing, reads 0)
//   2 CH_MASK  RW  [N_CH-1:0] channel enable mask
//   3 POLY     RW  [LFSR_WIDTH-1:0]
//   4 SEED     WO  write loads ch_seed_o; ch_seed_we_o[CH_SEL] pulses next cycle
//   5 CH_SEL   RW  [2:0] seed target channel; values >=N_CH -> no pulse
//   6 TMW_MAX  RW  [TMW_WIDTH-1:0]
//   7 STATUS   RO  [7:0] level, [8] empty, [9] full, [10] overflow (sticky, W1C), [12:11] fsm state
//   8 DATA     RO  read returns FIFO head and pops it; empty -> 0, no pop
//   9 IRQ_THR  RW  [7:0] threshold (IRQ_EN only, else reads 0)
//  rdata_o valid one cycle after en_i with we_i==0; DATA pop takes effect on the same edge.
//  FSM: IDLE -start&|CH_MASK-> RUN; RUN -!start-> STOP; STOP (1 cycle) -> IDLE.
//   ch_en_o = CH_MASK in RUN, 0 otherwise; mask changes during RUN apply next cycle.
//  Collect (RUN only): round-robin pointer; each cycle accept lowest enabled+valid channel at/after pointer;
//   pointer -> granted+1 mod N_CH. Other valid words in the same cycle are dropped, no flag.
//  Push when FIFO full: word dropped, overflow set. Push+pop same cycle: both occur, level unchanged.
//  flush: pointers/level to 0 next cycle; overrides a same-cycle push/pop; overflow unaffected.
//  Level: $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[7:0].
//  Async reset mid-operation: FIFO content discarded, channels disabled immediately.
// CONFIGURATION
//  TRNG_IRQ_EN defined: IRQ_THR register present; irq_o = (level >= IRQ_THR) & (IRQ_THR != 0) | overflow, registered.
//  Not defined: IRQ_THR reads 0, writes ignored, irq_o tied 0.
// TESTING
//  Reset -> all outputs 0, STATUS reads 0x100 (empty), FSM IDLE.
//  CH_MASK=0x5, CTRL=1, valid pulses ch0=0xA5A5A5A5, ch2=0x5A5A5A5A -> ch_en_o=0x5; DATA reads return them in order; STATUS empty after.
//  All 4 channels valid every cycle for 20 cycles, depth 16 -> level 16, full=1, overflow=1; write STATUS[10]=1 -> overflow 0.
//  CH_SEL=2, SEED=0x1234 -> ch_seed_o=0x1234, ch_seed_we_o=0x4 for exactly one cycle; CH_SEL=7 -> no pulse.
//  FIFO holding 3 words, DATA read on same cycle as push -> level stays 3; CTRL=2 (flush) -> level 0, STATUS empty.
//  TRNG_IRQ_EN, IRQ_THR=4 -> irq_o rises one cycle after 4th push; drops after one DATA read; rst low mid-RUN -> ch_en_o=0 at once.

Source files
------------

// File: rtl/trng_multi_ch_csr.sv
// trng_multi_ch_csr: CSR bank and sample collector for N_CH external entropy channels.
// Registered read data one cycle after a read strobe; a round-robin arbiter moves one
// valid channel word per cycle into a FIFO that is drained through a pop-on-read DATA register.
// Optional feature macro: TRNG_IRQ_EN (adds IRQ_THR register and a registered level interrupt).
// Ports:
//   clk, rst (async active-low)      : clock and reset
//   en_i, we_i, addr_i, wrdata_i     : bus slave access (any we_i bit set = write)
//   rdata_o                          : registered read data
//   ch_en_o, ch_poly_o, ch_tmw_max_o : channel run enable and shared configuration
//   ch_seed_o, ch_seed_we_o          : seed value and one-cycle per-channel load pulse
//   ch_data_i, ch_valid_i            : channel words and their one-cycle valid pulses
//   irq_o                            : level interrupt (0 unless TRNG_IRQ_EN)
module trng_multi_ch_csr #(
  parameter int ADDR_WIDTH = 13,
  parameter int N_CH       = 4,
  parameter int LFSR_WIDTH = 32,
  parameter int TMW_WIDTH  = 23,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [3:0]                 we_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [31:0]                wrdata_i,
  output logic [31:0]                rdata_o,
  output logic [N_CH-1:0]            ch_en_o,
  output logic [LFSR_WIDTH-1:0]      ch_poly_o,
  output logic [TMW_WIDTH-1:0]       ch_tmw_max_o,
  output logic [LFSR_WIDTH-1:0]      ch_seed_o,
  output logic [N_CH-1:0]            ch_seed_we_o,
  input  logic [N_CH*LFSR_WIDTH-1:0] ch_data_i,
  input  logic [N_CH-1:0]            ch_valid_i,
  output logic                       irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = ADDR_WIDTH - 4;

  localparam logic [IW-1:0] R_CTRL    = IW'(1);
  localparam logic [IW-1:0] R_CH_MASK = IW'(2);
  localparam logic [IW-1:0] R_POLY    = IW'(3);
  localparam logic [IW-1:0] R_SEED    = IW'(4);
  localparam logic [IW-1:0] R_CH_SEL  = IW'(5);
  localparam logic [IW-1:0] R_TMW_MAX = IW'(6);
  localparam logic [IW-1:0] R_STATUS  = IW'(7);
  localparam logic [IW-1:0] R_DATA    = IW'(8);
`ifdef TRNG_IRQ_EN
  localparam logic [IW-1:0] R_IRQ_THR = IW'(9);
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

  state_t                state, state_n;
  logic                  start;
  logic [N_CH-1:0]       mask;
  logic [LFSR_WIDTH-1:0] poly;
  logic [2:0]            ch_sel;
  logic [TMW_WIDTH-1:0]  tmw_max;
  logic                  ovf;

  logic [LFSR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  empty, full;

  logic [IW-1:0] idx;
  logic          wr, rd;
  logic [31:0]   wmask;
  logic          flush_req, ovf_clr, seed_wr, pop, push_ok;
  logic [31:0]   rd_mux;
  logic [7:0]    sel_oh;

  logic [7:0]            cand;
  logic                  grant_vld;
  logic [2:0]            grant_ch;
  logic [2:0]            rr_ptr;
  logic [LFSR_WIDTH-1:0] grant_dat;

  logic unused_ok;
  assign unused_ok = ^{addr_i[3:0], sel_oh};

  // Byte-lane merge of bus write data into an existing register value.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  assign idx   = addr_i[ADDR_WIDTH-1:4];
  assign wr    = en_i & (|we_i);
  assign rd    = en_i & ~(|we_i);
  assign wmask = {{8{we_i[3]}}, {8{we_i[2]}}, {8{we_i[1]}}, {8{we_i[0]}}};

  assign flush_req = wr && (idx == R_CTRL) && we_i[0] && wrdata_i[1];
  assign ovf_clr   = wr && (idx == R_STATUS) && we_i[1] && wrdata_i[10];
  assign seed_wr   = wr && (idx == R_SEED);

  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = rd && (idx == R_DATA) && !empty;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && (|mask)) state_n = S_RUN;
      S_RUN:   if (!start)           state_n = S_STOP;
      S_STOP:                        state_n = S_IDLE;
      default:                       state_n = S_IDLE;
    endcase
  end

  // Combinational so that an asynchronous reset disables the channels immediately.
  assign ch_en_o = (state == S_RUN) ? mask : '0;

  // ---------------- round-robin collect ----------------
  assign cand = (state == S_RUN) ? 8'(ch_valid_i & mask) : 8'd0;

  always_comb begin
    logic [3:0] c;
    grant_vld = 1'b0;
    grant_ch  = '0;
    c         = '0;
    for (int i = 0; i < N_CH; i++) begin
      c = {1'b0, rr_ptr} + 4'(i);
      if (c >= 4'(N_CH)) c = c - 4'(N_CH);
      if (!grant_vld && cand[c[2:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = c[2:0];
      end
    end
  end

  assign grant_dat = ch_data_i[grant_ch*LFSR_WIDTH +: LFSR_WIDTH];

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands then.
  assign push_ok = grant_vld && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_ch == 3'(N_CH - 1)) ? 3'd0 : grant_ch + 3'd1;
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_ok && !flush_req) mem[wr_ptr] <= grant_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  // ---------------- registers ----------------
  assign sel_oh = 8'd1 << ch_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start        <= 1'b0;
      mask         <= '0;
      poly         <= '0;
      ch_sel       <= '0;
      tmw_max      <= '0;
      ovf          <= 1'b0;
      ch_seed_o    <= '0;
      ch_seed_we_o <= '0;
    end else begin
      ch_seed_we_o <= seed_wr ? sel_oh[N_CH-1:0] : '0;
      if (wr) begin
        case (idx)
          R_CTRL:    if (we_i[0]) start <= wrdata_i[0];
          R_CH_MASK: mask    <= N_CH'(merge(32'(mask), wrdata_i, wmask));
          R_POLY:    poly    <= LFSR_WIDTH'(merge(32'(poly), wrdata_i, wmask));
          R_SEED:    ch_seed_o <= LFSR_WIDTH'(merge(32'(ch_seed_o), wrdata_i, wmask));
          R_CH_SEL:  ch_sel  <= 3'(merge(32'(ch_sel), wrdata_i, wmask));
          R_TMW_MAX: tmw_max <= TMW_WIDTH'(merge(32'(tmw_max), wrdata_i, wmask));
          default: ;
        endcase
      end
      // A new overflow in the same cycle as a W1C wins, so no event is lost.
      if (grant_vld && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)              ovf <= 1'b0;
    end
  end

  assign ch_poly_o    = poly;
  assign ch_tmw_max_o = tmw_max;

`ifdef TRNG_IRQ_EN
  logic [7:0] irq_thr;
  logic       irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_thr <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr && (idx == R_IRQ_THR)) irq_thr <= 8'(merge(32'(irq_thr), wrdata_i, wmask));
      irq_q <= ((8'(level) >= irq_thr) && (irq_thr != 8'd0)) || ovf;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // ---------------- read path ----------------
  always_comb begin
    rd_mux = '0;
    case (idx)
      R_CTRL:    rd_mux = {31'd0, start};
      R_CH_MASK: rd_mux = 32'(mask);
      R_POLY:    rd_mux = 32'(poly);
      R_CH_SEL:  rd_mux = 32'(ch_sel);
      R_TMW_MAX: rd_mux = 32'(tmw_max);
      R_STATUS:  rd_mux = 32'({state, ovf, full, empty, 8'(level)});
      R_DATA:    rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr]);
`ifdef TRNG_IRQ_EN
      R_IRQ_THR: rd_mux = 32'(irq_thr);
`endif
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata_o <= '0;
    else if (rd) rdata_o <= rd_mux;
  end

endmodule
